// File: rtl/instr_mem_loader_if.sv
// Word-stream input, byte-write output and status signals of instr_mem_loader.
// Optional INSTR_LOADER_CHECKSUM_EN adds the session checksum signal.
interface instr_mem_loader_if;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned BYTE_W = 8;

  logic              start;
  logic              in_valid;
  logic [WORD_W-1:0] in_word;
  logic              in_last;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [BYTE_W-1:0] mem_wdata;
  logic              busy;
  logic              done;
  logic              err;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] checksum;

  modport master (
    output start, in_valid, in_word, in_last,
    input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, checksum
  );
  modport slave (
    input  start, in_valid, in_word, in_last,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, checksum
  );
`else
  modport master (
    output start, in_valid, in_word, in_last,
    input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, err
  );
  modport slave (
    input  start, in_valid, in_word, in_last,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, done, err
  );
`endif
endinterface

// File: rtl/instr_mem_loader.sv
// Streams 32-bit instruction words into a byte-wide instruction memory, big-endian,
// one word per five cycles. Optional INSTR_LOADER_CHECKSUM_EN adds a session word sum.
module instr_mem_loader #(
  parameter int unsigned MEM_SIZE  = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic               clk,
  input  logic               rst,
  instr_mem_loader_if.slave  bus
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic               last_q, last_d;
  logic [1:0]         k_q, k_d;
  logic               err_q, err_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [BYTE_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic               overflow_c;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0]  checksum_q, checksum_d;
`endif

  // A word fits only if its last byte lands inside memory; 33 bits so ptr+3 cannot wrap.
  assign overflow_c = (33'({1'b0, ptr_q}) + 33'd3) >= 33'(MEM_SIZE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= BASE_ADDR;
      word_q      <= '0;
      last_q      <= 1'b0;
      k_q         <= 2'd0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      checksum_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      word_q      <= word_d;
      last_q      <= last_d;
      k_q         <= k_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
      checksum_q  <= checksum_d;
`endif
    end
  end

  // Session sequencing; outputs are decoded from the next state so they register cleanly.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    word_d      = word_q;
    last_d      = last_q;
    k_d         = k_q;
    err_d       = err_q;
    in_ready_d  = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
    checksum_d  = checksum_q;
`endif

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_LOAD;
          ptr_d   = BASE_ADDR;
          err_d   = 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
          checksum_d = '0;
`endif
        end
      end
      S_LOAD: begin
        if (bus.in_valid) begin
          if (overflow_c) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = S_WRITE;
            word_d  = bus.in_word;
            last_d  = bus.in_last;
            k_d     = 2'd0;
          end
        end
      end
      S_WRITE: begin
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) begin
          ptr_d   = ptr_q + 32'd4;
          state_d = last_q ? S_DONE : S_LOAD;
`ifdef INSTR_LOADER_CHECKSUM_EN
          checksum_d = checksum_q + word_q;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_LOAD);
    busy_d     = (state_d == S_LOAD) || (state_d == S_WRITE);
    done_d     = (state_d == S_DONE);
    if (state_d == S_WRITE) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = ptr_d + 32'(k_d);
      mem_wdata_d = 8'(word_d >> (5'd24 - {k_d, 3'b000}));
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
  assign bus.checksum  = checksum_q;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized self-checking bench for instr_mem_loader against a word/byte-level model.
module tb_instr_mem_loader;
  localparam int unsigned MEM_SIZE = 24;
  localparam logic [31:0] BASE     = 32'h0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_mem_loader_if bus ();
  instr_mem_loader #(.MEM_SIZE(MEM_SIZE), .BASE_ADDR(BASE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // model of one session: next free address, word sum, termination and error
  logic [31:0] m_ptr;
  logic [31:0] m_sum;
  bit          m_ended;
  bit          m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag, input logic busy_e, input logic done_e,
                              input logic err_e, input logic rdy_e);
    check({tag, "_busy"}, 32'(bus.busy), 32'(busy_e));
    check({tag, "_done"}, 32'(bus.done), 32'(done_e));
    check({tag, "_err"},  32'(bus.err),  32'(err_e));
    check({tag, "_rdy"},  32'(bus.in_ready), 32'(rdy_e));
  endtask

  task automatic check_no_write(input string tag);
    check({tag, "_we"},    32'(bus.mem_we), 32'd0);
    check({tag, "_addr"},  bus.mem_addr, 32'd0);
    check({tag, "_wdata"}, 32'(bus.mem_wdata), 32'd0);
  endtask

  task automatic check_sum(input string tag);
`ifdef INSTR_LOADER_CHECKSUM_EN
    check(tag, bus.checksum, m_sum);
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  task automatic start_session;
    bus.start = 1'b1;
    step;
    bus.start = 1'b0;
    m_ptr = BASE; m_sum = 32'd0; m_ended = 1'b0; m_err = 1'b0;
    check_status("start", 1'b1, 1'b0, 1'b0, 1'b1);
    check_no_write("start");
  endtask

  task automatic send_word(input logic [31:0] w, input logic last, input int gap, input bit noise);
    int  wait_cnt;
    bit  ovf;
    logic [7:0] b;
    repeat (gap) begin
      bus.in_valid = 1'b0;
      check_status("gap", 1'b1, 1'b0, 1'b0, 1'b1);
      check_no_write("gap");
      step;
    end
    bus.in_valid = 1'b1;
    bus.in_word  = w;
    bus.in_last  = last;
    wait_cnt = 0;
    while (bus.in_ready !== 1'b1 && wait_cnt < 20) begin
      step;
      wait_cnt++;
    end
    check("ready_wait", 32'(wait_cnt), 32'd0);
    ovf = (33'({1'b0, m_ptr}) + 33'd3) >= 33'(MEM_SIZE);
    step;
    bus.in_valid = 1'b0;
    if (ovf) begin
      m_ended = 1'b1;
      m_err   = 1'b1;
      check_status("ovf", 1'b0, 1'b1, 1'b1, 1'b0);
      check_no_write("ovf");
      check_sum("ovf_sum");
    end else begin
      if (noise) begin
        bus.in_valid = 1'b1;
        bus.in_word  = $urandom;
        bus.in_last  = 1'($urandom);
        bus.start    = 1'b1;
      end
      for (int k = 0; k < 4; k++) begin
        b = w[31-8*k -: 8];
        check("wr_we", 32'(bus.mem_we), 32'd1);
        check("wr_addr", bus.mem_addr, m_ptr + 32'(k));
        check("wr_data", 32'(bus.mem_wdata), 32'(b));
        check_status("wr", 1'b1, 1'b0, 1'b0, 1'b0);
        step;
        bus.start = 1'b0;
      end
      bus.in_valid = 1'b0;
      m_ptr = m_ptr + 32'd4;
      m_sum = m_sum + w;
      if (last) begin
        m_ended = 1'b1;
        check_status("fin", 1'b0, 1'b1, 1'b0, 1'b0);
        check_no_write("fin");
        check_sum("fin_sum");
      end else begin
        check_status("next", 1'b1, 1'b0, 1'b0, 1'b1);
        check_no_write("next");
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw;
    rst = 1'b1;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_word = 32'd0; bus.in_last = 1'b0;
    #1;
    check_status("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    check_no_write("rst");
    step; step;
    rst = 1'b0;
    step;
    check_status("post_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    check_no_write("post_rst");

    // single final word, big-endian bytes at base
    start_session;
    send_word(32'h00500093, 1'b1, 0, 1'b0);

    // three back-to-back words, one accepted every five cycles
    start_session;
    send_word(32'h11223344, 1'b0, 0, 1'b0);
    send_word(32'h55667788, 1'b0, 0, 1'b0);
    send_word(32'h99AABBCC, 1'b1, 0, 1'b0);

    // words past capacity: the first non-fitting word is dropped
    start_session;
    for (int i = 0; i < 8 && !m_ended; i++) send_word($urandom, 1'b0, 0, 1'b0);
    check("ovf_ptr_model", m_ptr, 32'(MEM_SIZE));
    step;
    check_status("ovf_hold", 1'b0, 1'b1, 1'b1, 1'b0);

    // start pulses during writes are ignored; checksum wraps
    start_session;
    send_word(32'hFFFFFFFF, 1'b0, 1, 1'b1);
    send_word(32'h00000002, 1'b1, 0, 1'b1);
    check("wrap_sum_model", m_sum, 32'h00000001);

    // reset during the second byte aborts writing immediately
    start_session;
    bus.in_valid = 1'b1; bus.in_word = 32'hDEADBEEF; bus.in_last = 1'b1;
    step;
    bus.in_valid = 1'b0;
    step;
    check("pre_rst_addr", bus.mem_addr, BASE + 32'd1);
    rst = 1'b1;
    #1;
    check_status("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    check_no_write("mid_rst");
    step;
    rst = 1'b0;
    step;
    check_status("rel_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    check_no_write("rel_rst");
    start_session;
    send_word(32'hCAFEF00D, 1'b1, 0, 1'b0);

    // randomized sessions
    for (int s = 0; s < 25; s++) begin
      nw = int'($urandom_range(1, 8));
      start_session;
      for (int i = 0; i < nw && !m_ended; i++)
        send_word($urandom, 1'(i == nw - 1), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      repeat (int'($urandom_range(1, 3))) begin
        bus.in_valid = 1'($urandom);
        bus.in_word  = $urandom;
        step;
        check_status("idle_done", 1'b0, 1'b1, m_err, 1'b0);
        check_no_write("idle_done");
      end
      bus.in_valid = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 1024, byte capacity of target instruction memory.
REQ-002 SHALL have parameter BASE_ADDR, default 0, first byte address written.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle pulse beginning a load session.
REQ-006 SHALL have port in_valid  input  1  source presents in_word.
REQ-007 SHALL have port in_word  input  32  instruction word to store.
REQ-008 SHALL have port in_last  input  1  qualifies in_word as final word of session.
REQ-009 SHALL have port in_ready  output  1  loader accepts a word this cycle.
REQ-010 SHALL have port mem_we  output  1  byte write enable to instruction memory.
REQ-011 SHALL have port mem_addr  output  32  byte address of write.
REQ-012 SHALL have port mem_wdata  output  8  byte data of write.
REQ-013 SHALL have port busy  output  1  session in progress.
REQ-014 SHALL have port done  output  1  session finished, held until next start.
REQ-015 SHALL have port err  output  1  session ended by address overflow, held until next start.

Function
REQ-016 SHALL implement states IDLE, LOAD, WRITE, DONE.
REQ-017 IDLE/DONE: start=1 -> LOAD; ptr<=BASE_ADDR; done, err cleared; start ignored in LOAD/WRITE.
REQ-018 LOAD: in_ready=1; transfer occurs when in_valid&&in_ready; in_word, in_last captured; next state WRITE.
REQ-019 in_ready SHALL be 0 in every state other than LOAD.
REQ-020 WRITE: four consecutive cycles, byte index k=0..3, mem_we=1, mem_addr=ptr+k, mem_wdata=word[31-8k:24-8k] (big-endian, MSB at lowest address).
REQ-021 Word transfer in cycle N SHALL produce writes in cycles N+1..N+4; next in_ready no earlier than N+5 (one word per 5 cycles).
REQ-022 After k=3: ptr<=ptr+4; captured in_last=1 -> DONE, else -> LOAD.
REQ-023 Overflow: transfer with ptr+3 > MEM_SIZE-1 SHALL drop the word (no mem_we), set err=1, done=1, go DONE.
REQ-024 mem_we SHALL be 0 outside WRITE; mem_addr, mem_wdata SHALL be 0 when mem_we=0.
REQ-025 busy=1 in LOAD and WRITE only; done=1 in DONE only.
REQ-026 ptr arithmetic 32-bit, unsigned; no wrap permitted (REQ-023 catches it first).
REQ-027 in_valid while not in LOAD SHALL have no effect; source must hold word until in_ready.

Reset
REQ-028 rst=1 SHALL immediately force IDLE, ptr=BASE_ADDR, captured word=0, k=0.
REQ-029 All outputs SHALL be 0 while rst=1 and in the first cycle after release.
REQ-030 rst mid-WRITE SHALL abort remaining byte writes in the same cycle; partial word left in memory is acceptable.

Configuration
REQ-031 Macro INSTR_LOADER_CHECKSUM_EN SHALL, when defined, add output checksum  32  modulo-2^32 sum of all words written this session, cleared on start, updated on final byte write of each word, dropped words excluded.
REQ-032 Without INSTR_LOADER_CHECKSUM_EN, checksum port and adder SHALL be absent; all other behaviour identical.

Verification
REQ-033 start, word 0x00500093 with in_last=1 -> cycles N+1..N+4 write 0x00,0x50,0x00,0x93 to addr 0..3; then done=1, busy=0.
REQ-034 Three words back-to-back with in_valid held high -> in_ready pulses every 5 cycles; addrs 0..11 written in order; done after third.
REQ-035 MEM_SIZE=8, three words, none last -> words at 0..7 written; third dropped; err=1, done=1, no write to addr 8.
REQ-036 rst asserted at second byte of a word -> mem_we=0 same cycle; IDLE; outputs 0; new start loads again from BASE_ADDR.
REQ-037 start pulsed during WRITE -> ignored; session completes unchanged.
REQ-038 With INSTR_LOADER_CHECKSUM_EN, words 0xFFFFFFFF and 0x00000002 -> checksum=0x00000001 at done.
